// File: rtl/serial_addsub_if.sv
// Start/done handshake and operand/result bundle for serial_addsub.
//   master: drives start, op, a, b, cin; observes busy, done, result and flags.
//   slave : the arithmetic unit itself.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [1:0]       op;      // 00 ADD, 01 ADC, 10 SUB, 11 SBB
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cf;
  logic             zf;
  logic             sf;
  logic             of;
  logic             af;
  logic             pf;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, cf, zf, sf, of, af, pf
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, cf, zf, sf, of, af, pf
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle 8086-style adder/subtractor (ADD/ADC/SUB/SBB), DIGIT bits per
// clock, LSB digit first, with full arithmetic flag set and start/done handshake.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : serial_addsub_if.slave (start/op/a/b/cin in; busy/done/result/flags out)
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus_io
);

  localparam int unsigned N       = WIDTH / DIGIT;
  localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AfSlice = 3 / DIGIT;  // slice holding bit 3
  localparam int unsigned AfBit   = 3 % DIGIT;  // bit 3's position inside that slice

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;       // already inverted for SUB/SBB
  logic              sub_q;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  acc_q;     // partial result, filled from the top
  logic              af_c_q;    // raw carry out of bit 3
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;
  logic              cf_q, zf_q, sf_q, of_q, af_q, pf_q;

  // Per-slice ripple, exposing every internal carry for AF/OF extraction.
  logic [DIGIT:0]         c;
  logic [DIGIT-1:0]       s;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   last;
  logic                   af_raw;

  always_comb begin
    c[0] = carry_q;
    s    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
    acc_cat  = {s, acc_q};
    acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
    last     = (cnt_q == CntW'(N - 1));
    // With a single slice, bit 3 is processed on the final edge itself.
    af_raw   = (cnt_q == CntW'(AfSlice)) ? c[AfBit+1] : af_c_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      af_c_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      af_q     <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            a_q     <= bus_io.a;
            b_q     <= bus_io.op[1] ? ~bus_io.b : bus_io.b;
            sub_q   <= bus_io.op[1];
            // ADD 0, ADC cin, SUB 1, SBB ~cin
            carry_q <= bus_io.op[0] ? (bus_io.cin ^ bus_io.op[1]) : bus_io.op[1];
            cnt_q   <= '0;
            acc_q   <= '0;
            af_c_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= c[DIGIT];
          acc_q   <= acc_next;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(AfSlice)) af_c_q <= c[AfBit+1];
          if (last) begin
            result_q <= acc_next;
            cf_q     <= c[DIGIT] ^ sub_q;
            af_q     <= af_raw ^ sub_q;
            of_q     <= c[DIGIT-1] ^ c[DIGIT];
            zf_q     <= (acc_next == '0);
            sf_q     <= acc_next[WIDTH-1];
            pf_q     <= ~^acc_next[7:0];
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy   = busy_q;
  assign bus_io.done   = done_q;
  assign bus_io.result = result_q;
  assign bus_io.cf     = cf_q;
  assign bus_io.zf     = zf_q;
  assign bus_io.sf     = sf_q;
  assign bus_io.of     = of_q;
  assign bus_io.af     = af_q;
  assign bus_io.pf     = pf_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(16)) bus16 ();
  serial_addsub_if #(.WIDTH(8))  bus8s ();
  serial_addsub_if #(.WIDTH(8))  bus8p ();

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus_io(bus16));
  serial_addsub #(.WIDTH(8),  .DIGIT(1)) u_dut8s (.clk(clk), .rst_n(rst_n), .bus_io(bus8s));
  serial_addsub #(.WIDTH(8),  .DIGIT(8)) u_dut8p (.clk(clk), .rst_n(rst_n), .bus_io(bus8p));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] flags16();
    return {bus16.cf, bus16.zf, bus16.sf, bus16.of, bus16.af, bus16.pf};
  endfunction

  // Runs one 16-bit operation starting #1 after a clock edge. When disturb is
  // set, start is re-pulsed with junk operands throughout RUN and the held
  // result is checked against prev.
  task automatic op16(input string tag, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic cin, input logic [15:0] exp_res,
                      input logic [5:0] exp_flags, input bit disturb,
                      input logic [15:0] prev);
    int k;
    bus16.op = op; bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    check({tag, " busy after start"}, 32'(bus16.busy), 32'd1);
    k = 0;
    while (!bus16.done && k < 20) begin
      if (disturb) begin
        check({tag, " result held"}, 32'(bus16.result), 32'(prev));
        bus16.start = 1'b1;
        bus16.op    = 2'b10;
        bus16.a     = 16'($urandom);
        bus16.b     = 16'($urandom);
        bus16.cin   = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    bus16.start = 1'b0;
    check({tag, " latency"}, 32'(k), 32'd4);
    check({tag, " result"}, 32'(bus16.result), 32'(exp_res));
    check({tag, " flags"}, 32'(flags16()), 32'(exp_flags));
    @(posedge clk); #1;
    check({tag, " done width"}, 32'(bus16.done), 32'd0);
    check({tag, " busy falls"}, 32'(bus16.busy), 32'd0);
    check({tag, " result kept"}, 32'(bus16.result), 32'(exp_res));
  endtask

  initial begin
    int ks, kp;
    bus16.start = 0; bus16.op = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0;
    bus8s.start = 0; bus8s.op = 0; bus8s.a = 0; bus8s.b = 0; bus8s.cin = 0;
    bus8p.start = 0; bus8p.op = 0; bus8p.a = 0; bus8p.b = 0; bus8p.cin = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus16.busy), 32'd0);
    check("reset done", 32'(bus16.done), 32'd0);
    check("reset result", 32'(bus16.result), 32'd0);
    check("reset flags", 32'(flags16()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flags order: {cf, zf, sf, of, af, pf}
    op16("add", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 6'b001111, 1'b0, 16'h0);
    op16("sub", 2'b10, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 6'b101011, 1'b0, 16'h0);
    op16("adc", 2'b01, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 6'b110011, 1'b0, 16'h0);
    op16("sbb", 2'b11, 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 6'b000111, 1'b0, 16'h0);
    op16("dist", 2'b00, 16'h0001, 16'h0002, 1'b0, 16'h0003, 6'b000001, 1'b1, 16'h7FFF);

    // Abort mid-RUN with a one-cycle reset pulse.
    bus16.op = 2'b00; bus16.a = 16'h0005; bus16.b = 16'h0006; bus16.cin = 0;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus16.busy), 32'd0);
    check("abort done", 32'(bus16.done), 32'd0);
    check("abort result", 32'(bus16.result), 32'd0);
    check("abort flags", 32'(flags16()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort no done", 32'(bus16.done), 32'd0);
    end
    op16("after", 2'b00, 16'h0003, 16'h0004, 1'b0, 16'h0007, 6'b000000, 1'b0, 16'h0);

    // 8-bit bit-serial and single-slice variants, run side by side.
    bus8s.op = 2'b00; bus8s.a = 8'h0F; bus8s.b = 8'h01; bus8s.cin = 0; bus8s.start = 1;
    bus8p.op = 2'b00; bus8p.a = 8'h0F; bus8p.b = 8'h01; bus8p.cin = 0; bus8p.start = 1;
    @(posedge clk); #1;
    bus8s.start = 0; bus8p.start = 0;
    ks = 0; kp = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus8s.done && ks == 0) begin
        ks = k;
        check("w8d1 result", 32'(bus8s.result), 32'h10);
        check("w8d1 flags", 32'({bus8s.cf, bus8s.zf, bus8s.sf, bus8s.of, bus8s.af, bus8s.pf}),
              32'b000010);
      end
      if (bus8p.done && kp == 0) begin
        kp = k;
        check("w8d8 result", 32'(bus8p.result), 32'h10);
        check("w8d8 flags", 32'({bus8p.cf, bus8p.zf, bus8p.sf, bus8p.of, bus8p.af, bus8p.pf}),
              32'b000010);
      end
    end
    check("w8d1 latency", 32'(ks), 32'd8);
    check("w8d8 latency", 32'(kp), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor for the processor datapath. It processes DIGIT bits per clock, LSB digit first, and supports the four 8086 arithmetic ops: ADD, ADC, SUB and SBB. It produces the full 8086 arithmetic flag set (CF, ZF, SF, OF, AF, PF) and uses a start/done handshake. It replaces the single-cycle ripple chain wherever area matters more than latency, for example the ALU slow path and the address unit.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be ≥ 8.
- DIGIT, 4, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT digit steps.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBB.
- a  in  WIDTH  minuend / first addend.
- b  in  WIDTH  subtrahend / second addend.
- cin  in  1  carry/borrow in; used by ADC/SBB only.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result.
- cf, zf, sf, of, af, pf  out  1 each  registered flags.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture a, op, and internal b' = (op[1] ? ~b : b).
  - Capture carry c0:
    - ADD: 0.
    - ADC: cin.
    - SUB: 1.
    - SBB: ~cin.
  - Clear digit counter; go to RUN.
  - Inputs may change freely after capture.
- RUN: each edge adds one DIGIT-bit slice of a and b' plus the running carry, then shifts the partial result into the result register.
  - Carry out of bit 3 is stored for AF when the slice containing bit 3 is processed.
  - Carry into bit WIDTH-1 is stored for OF.
  - On the edge that processes slice N-1:
    - Update result and all flags.
    - Assert done.
    - Go to DONE.
- DONE: on the next edge go to IDLE and clear done.
- start is ignored in RUN and DONE; there is no queuing.
- Flag rules (8086 semantics):
  - cf = final carry for ADD/ADC; inverted final carry (borrow) for SUB/SBB.
  - af = carry out of bit 3, inverted for SUB/SBB.
  - of = carry into MSB XOR carry out of MSB.
  - zf = (result == 0).
  - sf = result[WIDTH-1].
  - pf = 1 iff result[7:0] has an even number of ones.
- Visibility: result and flags hold their last values until the next completion. Intermediate partial results are never visible on result.
- Reset: state → IDLE. busy, done, result and all flags → 0. The internal operand, carry and counter registers are cleared.
  - Reset during RUN or DONE aborts the operation; no done is produced.

## Timing
- Latency: done rises N edges after the edge that samples start.
  - Example: WIDTH=16, DIGIT=4 gives done 4 edges after start.
  - result and flags are valid in the same cycle done is high.
- busy rises on the edge that samples start and falls on the edge that clears done.
- Throughput: one operation per N+2 cycles. A new start can be sampled at the earliest on the first IDLE cycle after DONE.
- done is exactly one cycle wide.
- Degenerate cases: DIGIT=WIDTH gives N=1 (done one edge after start). DIGIT=1 gives a bit-serial unit.

## Test plan
- ADD 0x7FFF+0x0001 (WIDTH 16, DIGIT 4) → result 0x8000, cf0 zf0 sf1 of1 af1 pf1. done exactly 4 edges after start and 1 cycle wide.
- SUB 0x0000−0x0001 → 0xFFFF, cf1 zf0 sf1 of0 af1 pf1.
- ADC 0xFFFF+0x0000, cin=1 → 0x0000, cf1 zf1 sf0 of0 af1 pf1. SBB 0x8000−0x0000, cin=1 → 0x7FFF, cf0 zf0 sf0 of1 af1 pf1.
- start pulsed again during RUN with different operands → ignored; the first result is unchanged.
  - Change a/b after capture → no effect on the result.
  - Previous result/flags held stable throughout RUN.
- rst_n low for one cycle during RUN → busy/done/result/flags all 0 immediately, no done pulse, IDLE.
  - A following ADD 0x0003+0x0004 → 0x0007, pf0.
- WIDTH=8, DIGIT=1: ADD 0x0F+0x01 → 0x10, cf0 af1 pf0 zf0 sf0 of0, done 8 edges after start.
  - WIDTH=8, DIGIT=8: same operands, done 1 edge after start.
